// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback writer: queue entry layout and
// pending-write counter width.
package wb_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    typedef logic [$clog2(WB_DEPTH+1)-1:0] wb_cnt_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    wb_entry_t   mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback writer: arbitrates ALU/LSU results into a queue, drives one
// register-file write per cycle and tracks pending writes per register.
module wb_writer #(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int NREG  = wb_pkg::NREG,
    parameter int DEPTH = wb_pkg::WB_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    output logic [NREG-1:0] busy,
    output logic            RegWrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wr_data,
    output logic            idle
);
    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            push_s;
    wb_entry_t       push_entry_s;
    wb_entry_t       head_s;
    logic            lsu_take_s;
    logic            alu_take_s;
    logic            reg_write_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] wr_data_r;
    logic [CNT_W-1:0] cnt_r     [NREG];
    logic [CNT_W-1:0] cnt_nxt_s [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Readies depend only on the registered full flag, never on own valid
    assign lsu_ready   = !fifo_full_s;
    assign alu_ready   = !fifo_full_s && !lsu_valid;
    assign issue_stall = issue_valid && (issue_rd != 5'd0) &&
                         (cnt_r[issue_rd] == CNT_W'(DEPTH));
    assign RegWrite    = reg_write_r;
    assign rd          = rd_r;
    assign wr_data     = wr_data_r;
    assign busy        = busy_r;
    assign idle        = fifo_empty_s && !reg_write_r;

    // Fixed-priority arbiter with x0 filter
    always_comb begin
        lsu_take_s   = lsu_valid && !fifo_full_s;
        alu_take_s   = alu_valid && !fifo_full_s && !lsu_valid;
        push_entry_s = '{rd: 5'd0, data: '0};
        if (lsu_take_s) begin
            push_entry_s = '{rd: lsu_rd, data: lsu_data};
        end else if (alu_take_s) begin
            push_entry_s = '{rd: alu_rd, data: alu_data};
        end else begin
            push_entry_s = '{rd: 5'd0, data: '0};
        end
        push_s = (lsu_take_s || alu_take_s) && (push_entry_s.rd != 5'd0);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (!fifo_empty_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Output register: rd/data hold their last values when nothing pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r <= 1'b0;
            rd_r        <= 5'd0;
            wr_data_r   <= '0;
        end else begin
            reg_write_r <= !fifo_empty_s;
            if (!fifo_empty_s) begin
                rd_r      <= head_s.rd;
                wr_data_r <= head_s.data;
            end
        end
    end

    // Scoreboard next state: simultaneous inc/dec cancels, dec never underflows
    always_comb begin
        logic inc_v;
        logic dec_v;
        for (int i = 0; i < NREG; i++) begin
            inc_v = issue_valid && !issue_stall && (issue_rd == 5'(i));
            dec_v = reg_write_r && (rd_r == 5'(i)) && (cnt_r[i] != '0);
            if (i == 0) begin
                cnt_nxt_s[i] = '0;
            end else if (inc_v && !dec_v) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end else if (dec_v && !inc_v) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            busy_nxt_s[i] = (i != 0) && (cnt_nxt_s[i] != '0);
        end
    end

    // Scoreboard counters and registered busy vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= '0;
            end
            busy_r <= '0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_writer;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0;
    logic            alu_ready, lsu_ready;
    logic [4:0]      alu_rd = 5'd0, lsu_rd = 5'd0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = 5'd0;
    logic            issue_stall;
    logic [NREG-1:0] busy;
    logic            RegWrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] wr_data;
    logic            idle;

    wb_writer #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
        .busy(busy), .RegWrite(RegWrite), .rd(rd), .wr_data(wr_data), .idle(idle)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_writes = 0;
    bit    chk_en = 1'b0;

    // Sources and behavioural model state
    item_t lsu_q[$];
    item_t alu_q[$];
    item_t exp_q[$];
    bit    exp_rw = 1'b0;
    int    exp_rd = 0;
    logic [31:0] exp_data = '0;
    int    cnt [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_rw = 1'b0;
        exp_rd = 0;
        exp_data = '0;
        for (int i = 0; i < NREG; i++) cnt[i] = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs seen at that edge
    task automatic model_step();
        bit    full, stall, inc, dec;
        int    irdx;
        item_t it;
        full  = (exp_q.size() == DEPTH);
        irdx  = int'(issue_rd);
        stall = issue_valid && irdx != 0 && cnt[irdx] == DEPTH;
        inc   = issue_valid && irdx != 0 && !stall;
        dec   = exp_rw && cnt[exp_rd] > 0;
        if (!(inc && dec && irdx == exp_rd)) begin
            if (inc) cnt[irdx]++;
            if (dec) cnt[exp_rd]--;
        end
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            exp_rw = 1'b1;
            exp_rd = int'(it.rd);
            exp_data = it.data;
        end else begin
            exp_rw = 1'b0;
        end
        if (!full && lsu_valid) begin
            it.rd = lsu_rd; it.data = lsu_data;
            void'(lsu_q.pop_front());
            if (it.rd != 5'd0) exp_q.push_back(it);
        end else if (!full && alu_valid) begin
            it.rd = alu_rd; it.data = alu_data;
            void'(alu_q.pop_front());
            if (it.rd != 5'd0) exp_q.push_back(it);
        end
    endtask

    task automatic apply();
        lsu_valid = (lsu_q.size() != 0);
        if (lsu_valid) begin lsu_rd = lsu_q[0].rd; lsu_data = lsu_q[0].data; end
        alu_valid = (alu_q.size() != 0);
        if (alu_valid) begin alu_rd = alu_q[0].rd; alu_data = alu_q[0].data; end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        apply();
    endtask

    task automatic drain(input int max_cycles);
        bit done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            cycle();
            done = (lsu_q.size() == 0) && (alu_q.size() == 0) && (exp_q.size() == 0) && !exp_rw;
        end
        check("drain_done", done, 1);
    endtask

    task automatic push_src(input bit to_lsu, input logic [4:0] r, input logic [31:0] d);
        item_t it;
        it.rd = r; it.data = d;
        if (to_lsu) lsu_q.push_back(it); else alu_q.push_back(it);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NREG-1:0] eb;
            for (int i = 0; i < NREG; i++) eb[i] = (cnt[i] != 0);
            check("RegWrite", RegWrite, exp_rw);
            check("rd", rd, exp_rd);
            check("wr_data", wr_data, exp_data);
            check("busy", busy, eb);
            check("idle", idle, (exp_q.size() == 0) && !exp_rw);
            check("lsu_ready", lsu_ready, exp_q.size() != DEPTH);
            check("alu_ready", alu_ready, (exp_q.size() != DEPTH) && !lsu_valid);
            check("issue_stall", issue_stall,
                  issue_valid && issue_rd != 5'd0 && cnt[issue_rd] == DEPTH);
            if (RegWrite) n_writes++;
        end
    end

    initial begin
        int w0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_idle", idle, 1);
        check("rst_busy", busy, 0);
        check("rst_lsu_ready", lsu_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single ALU write
        push_src(1'b0, 5'd5, 32'hDEADBEEF);
        apply();
        cycle();
        cycle();
        check("t1_RegWrite", RegWrite, 1);
        check("t1_rd", rd, 5);
        check("t1_wr_data", wr_data, 32'hDEADBEEF);
        cycle();
        check("t1_idle", idle, 1);

        // LSU priority over ALU
        push_src(1'b1, 5'd3, 32'h0000_0333);
        push_src(1'b0, 5'd4, 32'h0000_0444);
        apply();
        #1;
        check("t2_alu_ready_low", alu_ready, 0);
        check("t2_lsu_ready", lsu_ready, 1);
        cycle();
        cycle();
        check("t2_first_rd", rd, 3);
        cycle();
        check("t2_second_rd", rd, 4);
        check("t2_second_rw", RegWrite, 1);
        cycle();

        // x0 discard
        w0 = n_writes;
        push_src(1'b0, 5'd0, 32'h0000_1234);
        apply();
        cycle();
        check("t3_handshake", alu_q.size(), 0);
        cycle(); cycle();
        check("t3_no_write", n_writes - w0, 0);
        check("t3_busy", busy, 0);

        // Five back-to-back results with both sources valid
        w0 = n_writes;
        for (int k = 0; k < 3; k++) push_src(1'b1, 5'(10 + k), $urandom);
        for (int k = 0; k < 2; k++) push_src(1'b0, 5'(13 + k), $urandom);
        apply();
        drain(20);
        check("t4_write_count", n_writes - w0, 5);

        // Scoreboard
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle(); cycle();
        issue_valid = 1'b0;
        #1;
        check("sb_busy7_issued", busy[7], 1);
        push_src(1'b0, 5'd7, 32'h7777_0001);
        apply();
        drain(10);
        check("sb_busy7_after_one", busy[7], 1);
        push_src(1'b0, 5'd7, 32'h7777_0002);
        apply();
        drain(10);
        check("sb_busy7_after_two", busy[7], 0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0;
        push_src(1'b0, 5'd7, 32'h7777_0003);
        apply();
        cycle(); cycle();
        check("sb_same_rw", RegWrite, 1);
        check("sb_same_rd", rd, 7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0;
        #1;
        check("sb_same_keep", busy[7], 1);
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle(); cycle(); cycle();
        #1;
        check("sb_stall", issue_stall, 1);
        issue_rd = 5'd0;
        #1;
        check("sb_stall_x0", issue_stall, 0);
        issue_valid = 1'b0;

        // Asynchronous reset with work in flight
        issue_valid = 1'b1; issue_rd = 5'd9;
        push_src(1'b1, 5'd12, 32'hAAAA_0012);
        push_src(1'b0, 5'd9, 32'h9999_0009);
        apply();
        cycle();
        issue_valid = 1'b0;
        cycle();
        check("pre_reset_rw", RegWrite, 1);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_RegWrite", RegWrite, 0);
        check("arst_rd", rd, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_idle", idle, 1);
        lsu_q.delete(); alu_q.delete();
        apply();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        w0 = n_writes;
        repeat (4) cycle();
        check("post_reset_no_write", n_writes - w0, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0 && lsu_q.size() < 3)
                push_src(1'b1, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0 && alu_q.size() < 3)
                push_src(1'b0, 5'($urandom_range(0, 7)), $urandom);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd = 5'($urandom_range(0, 7));
            apply();
            cycle();
        end
        issue_valid = 1'b0;
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
